// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 7-segment scanner with frame-aligned double buffering
// Optional leading-zero blanking: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan #(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  output logic [3:0]                digit_out,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start,
  output logic                      pending
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic                  frame_start_q, frame_start_d;
  logic                  pending_q, pending_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         pend_buf_q, pend_buf_d;

  logic                  tick;
  logic [IW-1:0]         idx_next;
  logic                  upper_nonzero;

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    an_d          = an_q;
    digit_d       = digit_q;
    frame_start_d = 1'b0;
    pending_d     = pending_q;
    active_d      = active_q;
    pend_buf_d    = pend_buf_q;
    idx_next      = idx_q;
    upper_nonzero = 1'b0;

    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    if (load) begin
      pend_buf_d = value;
      pending_d  = 1'b1;
    end

    if (tick) begin
      idx_next = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      idx_d    = idx_next;

      // Frame boundary: a same-cycle load bypasses the pending buffer.
      if (idx_next == '0) begin
        frame_start_d = 1'b1;
        if (load) begin
          active_d  = value;
          pending_d = 1'b0;
        end else if (pending_q) begin
          active_d  = pend_buf_q;
          pending_d = 1'b0;
        end
      end

      an_d    = '1;
      digit_d = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_next == IW'(k)) begin
          an_d[k] = 1'b0;
          digit_d = active_d[4*k +: 4];
        end
        if (IW'(k) >= idx_next && active_d[4*k +: 4] != 4'h0) begin
          upper_nonzero = 1'b1;
        end
      end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if (idx_next != '0 && !upper_nonzero) begin
        an_d    = '1;
        digit_d = 4'h0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= IDX_MAX;
      an_q          <= '1;
      digit_q       <= 4'h0;
      frame_start_q <= 1'b0;
      pending_q     <= 1'b0;
      active_q      <= '0;
      pend_buf_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      pend_buf_q    <= pend_buf_d;
    end
  end

  assign digit_out   = digit_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan against a cycle-count reference model
// Honours SEG_SCAN_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan;
  localparam int CLK_DIV = 4;
  localparam int ND      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  seg_scan #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .digit_out(digit_out), .an(an), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference: n = edges since reset release; ticks = n / CLK_DIV decide the lit digit.
  int          n = 0;
  int          cur_idx = -1;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_latest = 16'h0;
  bit          m_has_new = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit next_is_boundary(input int cur);
    int nn;
    nn = cur + 1;
    return (nn >= CLK_DIV) && (nn % CLK_DIV == 0) && (((nn / CLK_DIV) - 1) % ND == 0);
  endfunction

  task automatic step(input bit r, input bit l, input logic [15:0] v);
    bit          boundary;
    logic [3:0]  exp_an;
    logic [3:0]  exp_dig;
    logic [15:0] upper;
    rst = r; load = l; value = v;
    @(posedge clk);
    boundary = 1'b0;
    if (r) begin
      n = 0; cur_idx = -1;
      m_active = 16'h0; m_latest = 16'h0; m_has_new = 1'b0;
    end else begin
      n++;
      if (n >= CLK_DIV) cur_idx = ((n / CLK_DIV) - 1) % ND;
      boundary = (n % CLK_DIV == 0) && (cur_idx == 0);
      if (boundary && l) begin
        m_active = v; m_has_new = 1'b0;
      end else if (boundary && m_has_new) begin
        m_active = m_latest; m_has_new = 1'b0;
      end else if (!boundary && l) begin
        m_latest = v; m_has_new = 1'b1;
      end
    end
    exp_an  = 4'hF;
    exp_dig = 4'h0;
    if (cur_idx >= 0) begin
      upper   = m_active >> (4 * cur_idx);
      exp_an  = ~(4'h1 << cur_idx);
      exp_dig = upper[3:0];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if (cur_idx > 0 && upper == 16'h0) begin
        exp_an  = 4'hF;
        exp_dig = 4'h0;
      end
`endif
    end
    #1;
    check("an", {12'h0, an}, {12'h0, exp_an});
    check("digit_out", {12'h0, digit_out}, {12'h0, exp_dig});
    check("frame_start", {15'h0, frame_start}, {15'h0, boundary});
    check("pending", {15'h0, pending}, {15'h0, m_has_new});
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] rv;
    logic [15:0] mask;
    int          guard;

    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    check("reset_an", {12'h0, an}, 16'h000F);
    check("reset_digit", {12'h0, digit_out}, 16'h0000);

    // Load at cycle 1; the first tick at cycle 4 lights digit 0 with the new value.
    step(1'b0, 1'b1, 16'h1234);
    check("pending_after_load", {15'h0, pending}, 16'h0001);
    idle(3);
    check("first_tick_an", {12'h0, an}, 16'h000E);
    check("first_tick_digit", {12'h0, digit_out}, 16'h0004);
    check("first_tick_fs", {15'h0, frame_start}, 16'h0001);
    check("first_tick_pending", {15'h0, pending}, 16'h0000);
    idle(4);
    check("slot1_an", {12'h0, an}, 16'h000D);
    check("slot1_digit", {12'h0, digit_out}, 16'h0003);
    idle(16);

    // Mid-frame load while digit 1 is shown.
    guard = 0;
    while (cur_idx != 1 && guard < 100) begin idle(1); guard++; end
    check("wait_idx1", (guard < 100) ? 16'h1 : 16'h0, 16'h1);
    step(1'b0, 1'b1, 16'hABCD);
    idle(24);

    // Two loads in one frame; only the last is shown.
    step(1'b0, 1'b1, 16'h1111);
    step(1'b0, 1'b1, 16'h2222);
    idle(24);

    // Load exactly on the boundary tick.
    guard = 0;
    while (!next_is_boundary(n) && guard < 100) begin idle(1); guard++; end
    check("wait_boundary", (guard < 100) ? 16'h1 : 16'h0, 16'h1);
    step(1'b0, 1'b1, 16'h5678);
    check("bypass_an", {12'h0, an}, 16'h000E);
    check("bypass_digit", {12'h0, digit_out}, 16'h0008);
    check("bypass_pending", {15'h0, pending}, 16'h0000);
    idle(16);

    // Reset while digit 2 is active with a value pending.
    guard = 0;
    while (cur_idx != 1 && guard < 100) begin idle(1); guard++; end
    step(1'b0, 1'b1, 16'hABCD);
    while (cur_idx != 2 && guard < 200) begin idle(1); guard++; end
    check("wait_idx2", (guard < 200) ? 16'h1 : 16'h0, 16'h1);
    check("pending_before_rst", {15'h0, pending}, 16'h0001);
    step(1'b1, 1'b0, 16'h0);
    check("rst_mid_an", {12'h0, an}, 16'h000F);
    check("rst_mid_pending", {15'h0, pending}, 16'h0000);
    idle(20);

    // Leading-zero candidates (blanked only when the macro is defined).
    step(1'b0, 1'b1, 16'h0070);
    idle(24);
    step(1'b0, 1'b1, 16'h0000);
    idle(24);

    for (int i = 0; i < 2000; i++) begin
      rv   = 16'($urandom);
      mask = 16'hFFFF >> (4 * ($urandom % 4));
      step(($urandom % 250) == 0, ($urandom % 6) == 0, rv & mask);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scanner for a common-anode 4-digit 7-segment display.
- Holds a hex value and selects one nibble per refresh slot, feeding the nibble to the downstream 7-segment decoder (4-bit hex in, active-low segments out).
- Drives the matching active-low digit enable.
- New values are double-buffered and applied only at frame boundaries, so a display frame never mixes old and new digits.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot (refresh prescaler); legal range >= 1.
- NUM_DIGITS, 4, number of multiplexed digits; value width is 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- value  input  4*NUM_DIGITS  hex value to display; nibble k goes to digit k, digit 0 rightmost/LSB.
- load  input  1  single-cycle strobe; captures value into the pending buffer.
- digit_out  output  4  nibble for the current digit, to the decoder input.
- an  output  NUM_DIGITS  digit enables, active-low, one-cold while scanning.
- frame_start  output  1  one-cycle pulse when digit 0 becomes active.
- pending  output  1  high while a loaded value awaits the next frame boundary.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: prescaler = 0, idx = NUM_DIGITS-1, an = all ones (display dark), digit_out = 0, frame_start = 0, pending = 0, active buffer = 0, pending buffer = 0.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick is asserted in the cycle where the count equals CLK_DIV-1. With CLK_DIV=1, tick is asserted every cycle. Counter width is clog2(CLK_DIV), minimum 1.
- On tick:
  - idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - an and digit_out update in the same edge for the new idx.
  - an[new idx] = 0 and all other an bits = 1.
  - digit_out = active[4*new_idx +: 4].
- The first tick after reset therefore lights digit 0, CLK_DIV cycles after rst deasserts.
- Frame boundary: a tick where the new idx = 0.
  - frame_start = 1 for exactly that one cycle (registered with the an update).
  - If pending = 1, the pending buffer is copied to active on that edge, pending clears, and digit_out for digit 0 reflects the new value in the same cycle.
- load:
  - On load = 1, the pending buffer <= value and pending <= 1.
  - Repeated loads before a boundary overwrite the buffer; only the last one is shown.
- load coincident with a boundary tick: value bypasses directly into active, pending stays 0, and digit 0 shows the new value immediately.
- Between boundaries: the active buffer is stable and never changes mid-frame.
- rst mid-scan: takes precedence over load and tick, returns every register to its reset value, and any pending value is discarded.
- Stall-free: there is no backpressure, and load is accepted every cycle.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - During a digit slot k > 0, if nibbles k..NUM_DIGITS-1 of active are all zero, the digit is blanked: an stays all ones for that slot and digit_out = 0.
  - Digit 0 is never blanked, so value 0 displays as a single "0".
  - Slot timing, idx advance and frame_start are unchanged.
- Undefined: all digits are always enabled in turn and leading zeros are displayed.

Test Plan:
- Reset release with CLK_DIV=4 and value=16'h1234 loaded at cycle 1 -> an=4'b1111 until the first tick at cycle 4. At that tick frame_start=1, an=4'b1110, digit_out=4, pending goes from 1 to 0. Then every 4 cycles: an=1101/digit_out 3, an=1011/2, an=0111/1, then wrap to 1110/4 with frame_start=1.
- Mid-frame load of 16'hABCD while digit 1 is displayed (active=16'h1234) -> digits 2 and 3 still show 2 and 1, pending=1. At the next boundary digit_out=D, then C, B, A, and pending=0.
- Two loads (16'h1111 then 16'h2222) within one frame -> the next frame shows 2222 only; 1111 never appears on digit_out.
- load of 16'h5678 exactly on the boundary tick cycle -> same edge: an=1110, digit_out=8, pending remains 0.
- rst asserted while digit 2 is active with pending=1 -> next cycle: an=4'b1111, digit_out=0, pending=0. After release, the first frame shows 0000.
- With SEG_SCAN_LEADING_ZERO_BLANK_EN defined and active=16'h0070 -> digit slots 0 and 1 show an=1110/0 and 1101/7. Slots 2 and 3 keep an=1111. For active=16'h0000 only digit 0 lights, showing 0.
